ex_branch_stage: RTL and testbench

ID/EX pipeline register plus branch resolver: the consuming end of the decode control bundle. Each cycle it captures the control word the decoder emits, together with the operand values, PC and immediate. It resolves BEZ/BNE/JMP in EX and drives the redirect and flush signals back toward IF/ID. It also inserts bubbles on hazard stalls and counts taken branches.

---
 rtl/ex_branch_stage.sv | 153 +++++++++++++++
 tb/tb_ex_branch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_branch_stage.sv
// ID/EX pipeline register with branch resolution in EX.
// Resolves BEZ/BNE/JMP from the registered control word and redirects/flushes the front end.
module ex_branch_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       id_condition_check,
  input  logic             id_is_brj,
  input  logic             id_is_imm,
  input  logic             id_st_bne,
  input  logic [1:0]       id_mem_signals,
  input  logic             id_wb_en,
  input  logic [3:0]       id_ex_command,
  input  logic [WIDTH-1:0] id_val1,
  input  logic [WIDTH-1:0] id_val2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [WIDTH-1:0] id_pc,
  input  logic             stall,
  output logic             ex_is_imm,
  output logic             ex_st_bne,
  output logic             ex_wb_en,
  output logic [1:0]       ex_mem_signals,
  output logic [3:0]       ex_ex_command,
  output logic [WIDTH-1:0] ex_val1,
  output logic [WIDTH-1:0] ex_val2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [WIDTH-1:0] ex_pc,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr,
  output logic             flush_if,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [1:0] COND_BEZ  = 2'b00;
  localparam logic [1:0] COND_BNE  = 2'b01;
  localparam logic [1:0] COND_JMP  = 2'b10;
  localparam logic [1:0] COND_NONE = 2'b11;

  logic [1:0]       cond_q, cond_d;
  logic             is_brj_q, is_brj_d;
  logic             is_imm_q, is_imm_d;
  logic             st_bne_q, st_bne_d;
  logic [1:0]       mem_q, mem_d;
  logic             wb_en_q, wb_en_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] val1_q, val1_d;
  logic [WIDTH-1:0] val2_q, val2_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken_s;
  logic [WIDTH-1:0] target_s;

  // Branch decision is taken from the EX register only, so a bubble can never redirect.
  always_comb begin
    taken_s = 1'b0;
    if (is_brj_q) begin
      case (cond_q)
        COND_BEZ:  taken_s = (val1_q == {WIDTH{1'b0}});
        COND_BNE:  taken_s = (val1_q != val2_q);
        COND_JMP:  taken_s = 1'b1;
        COND_NONE: taken_s = 1'b0;
        default:   taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
    target_s = pc_q + (imm_q << 2);
  end

  // Next EX contents: a taken branch squashes ID ahead of the stall bubble.
  always_comb begin
    cond_d   = COND_NONE;
    is_brj_d = 1'b0;
    is_imm_d = 1'b0;
    st_bne_d = 1'b0;
    mem_d    = 2'b00;
    wb_en_d  = 1'b0;
    cmd_d    = 4'b0000;
    val1_d   = {WIDTH{1'b0}};
    val2_d   = {WIDTH{1'b0}};
    imm_d    = {WIDTH{1'b0}};
    pc_d     = {WIDTH{1'b0}};
    if (!(taken_s || stall)) begin
      cond_d   = id_condition_check;
      is_brj_d = id_is_brj;
      is_imm_d = id_is_imm;
      st_bne_d = id_st_bne;
      mem_d    = id_mem_signals;
      wb_en_d  = id_wb_en;
      cmd_d    = id_is_brj ? 4'b0000 : id_ex_command;
      val1_d   = id_val1;
      val2_d   = id_val2;
      imm_d    = id_imm;
      pc_d     = id_pc;
    end else begin
      cmd_d    = 4'b0000;
    end
    if (taken_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // EX register and taken counter; rst discards a branch sitting in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q   <= COND_NONE;
      is_brj_q <= 1'b0;
      is_imm_q <= 1'b0;
      st_bne_q <= 1'b0;
      mem_q    <= 2'b00;
      wb_en_q  <= 1'b0;
      cmd_q    <= 4'b0000;
      val1_q   <= {WIDTH{1'b0}};
      val2_q   <= {WIDTH{1'b0}};
      imm_q    <= {WIDTH{1'b0}};
      pc_q     <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      cond_q   <= cond_d;
      is_brj_q <= is_brj_d;
      is_imm_q <= is_imm_d;
      st_bne_q <= st_bne_d;
      mem_q    <= mem_d;
      wb_en_q  <= wb_en_d;
      cmd_q    <= cmd_d;
      val1_q   <= val1_d;
      val2_q   <= val2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_is_imm      = is_imm_q;
  assign ex_st_bne      = st_bne_q;
  assign ex_wb_en       = wb_en_q;
  assign ex_mem_signals = mem_q;
  assign ex_ex_command  = cmd_q;
  assign ex_val1        = val1_q;
  assign ex_val2        = val2_q;
  assign ex_imm         = imm_q;
  assign ex_pc          = pc_q;
  assign branch_taken   = taken_s;
  assign branch_addr    = taken_s ? target_s : {WIDTH{1'b0}};
  assign flush_if       = taken_s;
  assign taken_count    = cnt_q;

endmodule

// File: tb/tb_ex_branch_stage.sv
// Scoreboard bench for ex_branch_stage: a reference model pushes expected EX state per cycle,
// popped and compared one cycle later; a CNT_W=2 copy shares the stimulus to exercise saturation.
module tb_ex_branch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id_condition_check;
  logic        id_is_brj, id_is_imm, id_st_bne, id_wb_en, stall;
  logic [1:0]  id_mem_signals;
  logic [3:0]  id_ex_command;
  logic [31:0] id_val1, id_val2, id_imm, id_pc;

  logic        ex_is_imm, ex_st_bne, ex_wb_en, branch_taken, flush_if;
  logic [1:0]  ex_mem_signals;
  logic [3:0]  ex_ex_command;
  logic [31:0] ex_val1, ex_val2, ex_imm, ex_pc, branch_addr;
  logic [15:0] taken_count;

  logic        s_is_imm, s_st_bne, s_wb_en, s_taken, s_flush;
  logic [1:0]  s_mem;
  logic [3:0]  s_cmd;
  logic [31:0] s_val1, s_val2, s_imm, s_pc, s_addr;
  logic [1:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_branch_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_condition_check(id_condition_check), .id_is_brj(id_is_brj),
    .id_is_imm(id_is_imm), .id_st_bne(id_st_bne), .id_mem_signals(id_mem_signals),
    .id_wb_en(id_wb_en), .id_ex_command(id_ex_command), .id_val1(id_val1), .id_val2(id_val2),
    .id_imm(id_imm), .id_pc(id_pc), .stall(stall), .ex_is_imm(ex_is_imm), .ex_st_bne(ex_st_bne),
    .ex_wb_en(ex_wb_en), .ex_mem_signals(ex_mem_signals), .ex_ex_command(ex_ex_command),
    .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .flush_if(flush_if),
    .taken_count(taken_count)
  );

  ex_branch_stage #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_condition_check(id_condition_check), .id_is_brj(id_is_brj),
    .id_is_imm(id_is_imm), .id_st_bne(id_st_bne), .id_mem_signals(id_mem_signals),
    .id_wb_en(id_wb_en), .id_ex_command(id_ex_command), .id_val1(id_val1), .id_val2(id_val2),
    .id_imm(id_imm), .id_pc(id_pc), .stall(stall), .ex_is_imm(s_is_imm), .ex_st_bne(s_st_bne),
    .ex_wb_en(s_wb_en), .ex_mem_signals(s_mem), .ex_ex_command(s_cmd),
    .ex_val1(s_val1), .ex_val2(s_val2), .ex_imm(s_imm), .ex_pc(s_pc),
    .branch_taken(s_taken), .branch_addr(s_addr), .flush_if(s_flush),
    .taken_count(s_count)
  );

  typedef struct packed {
    logic        is_imm;
    logic        st_bne;
    logic        wb_en;
    logic [1:0]  mem;
    logic [3:0]  cmd;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] addr;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];

  // reference model of the EX register
  logic        m_brj, m_is_imm, m_st_bne, m_wb_en;
  logic [1:0]  m_cond, m_mem;
  logic [3:0]  m_cmd;
  logic [31:0] m_val1, m_val2, m_imm, m_pc;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_taken();
    if (!m_brj) return 1'b0;
    case (m_cond)
      2'b00:   return m_val1 == 32'd0;
      2'b01:   return m_val1 != m_val2;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_bubble();
    m_brj = 1'b0; m_cond = 2'b11; m_is_imm = 1'b0; m_st_bne = 1'b0; m_mem = 2'b00;
    m_wb_en = 1'b0; m_cmd = 4'b0000; m_val1 = 32'd0; m_val2 = 32'd0; m_imm = 32'd0; m_pc = 32'd0;
  endtask

  task automatic drive(input logic r, input logic [1:0] c, input logic brj, input logic ii,
                       input logic sb, input logic [1:0] ms, input logic wb, input logic [3:0] cmd,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] im,
                       input logic [31:0] p, input logic st);
    exp_t e;
    logic mt;
    rst = r; id_condition_check = c; id_is_brj = brj; id_is_imm = ii; id_st_bne = sb;
    id_mem_signals = ms; id_wb_en = wb; id_ex_command = cmd; id_val1 = v1; id_val2 = v2;
    id_imm = im; id_pc = p; stall = st;
    mt = model_taken();
    if (r) begin
      m_cnt = 16'd0; m_cnt2 = 2'd0;
    end else if (mt) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
    end
    if (r || mt || st) model_bubble();
    else begin
      m_brj = brj; m_cond = c; m_is_imm = ii; m_st_bne = sb; m_mem = ms; m_wb_en = wb;
      m_cmd = brj ? 4'b0000 : cmd; m_val1 = v1; m_val2 = v2; m_imm = im; m_pc = p;
    end
    e.is_imm = m_is_imm; e.st_bne = m_st_bne; e.wb_en = m_wb_en; e.mem = m_mem; e.cmd = m_cmd;
    e.val1 = m_val1; e.val2 = m_val2; e.imm = m_imm; e.pc = m_pc;
    e.taken = model_taken();
    e.addr = e.taken ? (m_pc + {m_imm[29:0], 2'b00}) : 32'd0;
    e.cnt = m_cnt; e.cnt2 = m_cnt2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 160'd0, 160'd1);
      return;
    end
    e = exp_q.pop_front();
    check("ex_is_imm", 160'(ex_is_imm), 160'(e.is_imm));
    check("ex_st_bne", 160'(ex_st_bne), 160'(e.st_bne));
    check("ex_wb_en", 160'(ex_wb_en), 160'(e.wb_en));
    check("ex_mem_signals", 160'(ex_mem_signals), 160'(e.mem));
    check("ex_ex_command", 160'(ex_ex_command), 160'(e.cmd));
    check("ex_val1", 160'(ex_val1), 160'(e.val1));
    check("ex_val2", 160'(ex_val2), 160'(e.val2));
    check("ex_imm", 160'(ex_imm), 160'(e.imm));
    check("ex_pc", 160'(ex_pc), 160'(e.pc));
    check("branch_taken", 160'(branch_taken), 160'(e.taken));
    check("flush_if", 160'(flush_if), 160'(e.taken));
    check("branch_addr", 160'(branch_addr), 160'(e.addr));
    check("taken_count", 160'(taken_count), 160'(e.cnt));
    check("sat_ctl", 160'({s_is_imm, s_st_bne, s_wb_en, s_mem, s_cmd, s_taken, s_flush}),
          160'({e.is_imm, e.st_bne, e.wb_en, e.mem, e.cmd, e.taken, e.taken}));
    check("sat_data", 160'({s_val1, s_val2, s_imm, s_pc, s_addr}),
          160'({e.val1, e.val2, e.imm, e.pc, e.addr}));
    check("sat_count", 160'(s_count), 160'(e.cnt2));
  endtask

  task automatic nop();
    drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic add_ins(input logic st);
    drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'h1, 32'd1, 32'd2, 32'd0, 32'h100, st);
  endtask

  task automatic jmp(input logic [31:0] p, input logic [31:0] im);
    drive(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'hF, 32'd0, 32'd0, im, p, 1'b0);
  endtask

  initial begin
    model_bubble();
    m_cnt = 16'd0; m_cnt2 = 2'd0;

    // reset with random ID contents
    for (int i = 0; i < 2; i++)
      drive(1'b1, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom, 1'($urandom));
    check("reset_wb_en", 160'(ex_wb_en), 160'd0);
    check("reset_count", 160'(taken_count), 160'd0);

    // ADDI pass-through
    drive(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'h0, 32'd5, 32'd0, 32'd7, 32'h10, 1'b0);
    check("addi_val1", 160'(ex_val1), 160'd5);

    // BEZ taken, ADD behind it is squashed
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'bxxxx, 32'd0, 32'd0, 32'd3, 32'h20, 1'b0);
    check("bez_addr", 160'(branch_addr), 160'h2C);
    check("bez_cmd_sanitised", 160'(ex_ex_command), 160'd0);
    add_ins(1'b0);
    check("bez_squash_wb", 160'(ex_wb_en), 160'd0);
    check("bez_count", 160'(taken_count), 160'd1);

    // BEZ not taken
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h3, 32'd4, 32'd0, 32'd3, 32'h20, 1'b0);
    check("bez_nt", 160'(branch_taken), 160'd0);
    nop();

    // BNE equal / unequal, JMP backwards with X command
    drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'h2, 32'd9, 32'd9, 32'd4, 32'h30, 1'b0);
    drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'h2, 32'd9, 32'd8, 32'd4, 32'h30, 1'b0);
    check("bne_taken", 160'(branch_taken), 160'd1);
    add_ins(1'b0);
    drive(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'bxxxx, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h40, 1'b0);
    check("jmp_addr", 160'(branch_addr), 160'h3C);
    nop();

    // sustained stall with LW in ID, then release
    for (int i = 0; i < 3; i++)
      drive(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'h0, 32'd8, 32'd0, 32'd4, 32'h50, 1'b1);
    drive(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'h0, 32'd8, 32'd0, 32'd4, 32'h50, 1'b0);
    check("lw_mem", 160'(ex_mem_signals), 160'h2);

    // back-to-back jumps, then taken branch coinciding with stall
    jmp(32'h60, 32'd1);
    jmp(32'h70, 32'd1);
    nop();
    jmp(32'h80, 32'd2);
    add_ins(1'b1);
    add_ins(1'b0);

    // saturation of the 2-bit copy
    for (int i = 0; i < 5; i++) begin
      jmp(32'h100 + 32'(i), 32'd1);
      nop();
    end
    check("sat_hold", 160'(s_count), 160'h3);

    // reset while a jump sits in EX
    jmp(32'h200, 32'd5);
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 4'h7, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    check("rst_count", 160'(taken_count), 160'd0);
    check("rst_taken", 160'(branch_taken), 160'd0);
    nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
